// File: rtl/DisplayPkg.sv
// Shared display/game types: tetromino encodings, bag size, LFSR seed.
// Also holds the bag-aware piece picker used by the preview queue.
package DisplayPkg;

    localparam int          NUM_TETROMINOS    = 7;
    localparam logic [15:0] DEFAULT_LFSR_SEED = 16'hACE1;

    typedef enum logic [2:0] {
        TILE_I = 3'd0,
        TILE_O = 3'd1,
        TILE_T = 3'd2,
        TILE_S = 3'd3,
        TILE_Z = 3'd4,
        TILE_J = 3'd5,
        TILE_L = 3'd6,
        BLANK  = 3'd7
    } tile_type_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } npq_state_t;

    // First type not yet used in this bag, searching upward from the
    // random index with wrap-around; 7 folds onto 0.
    function automatic logic [2:0] pick_piece(
        input logic [2:0] seed_idx,
        input logic [6:0] used
    );
        logic [2:0] start;
        logic [3:0] j;
        logic       found;
        start      = (seed_idx == 3'd7) ? 3'd0 : seed_idx;
        pick_piece = start;
        found      = 1'b0;
        for (int k = 0; k < NUM_TETROMINOS; k++) begin
            j = {1'b0, start} + 4'(k);
            if (j >= 4'd7) begin
                j = j - 4'd7;
            end
            if (!found && !used[j[2:0]]) begin
                pick_piece = j[2:0];
                found      = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, taps 16/14/13/11, free-running every cycle.
// reload restores the seed on the next edge instead of shifting.
module lfsr16
    import DisplayPkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_LFSR_SEED
) (
    input  logic        clk,
    input  logic        rst_l,
    input  logic        reload,
    output logic [15:0] value
);

    logic [15:0] r_lfsr;
    logic        w_fb;

    assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_lfsr <= SEED;
        end else if (reload) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_fb};
        end
    end

    assign value = r_lfsr;

endmodule

// File: rtl/next_piece_queue.sv
// 7-bag next-piece generator with a shift-down preview queue,
// pending fetch when empty, and hold-swap injection of the falling piece.
module next_piece_queue
    import DisplayPkg::*;
#(
    parameter int          PREVIEW_DEPTH = 5,
    parameter logic [15:0] LFSR_SEED     = DEFAULT_LFSR_SEED
) (
    input  logic                                 clk,
    input  logic                                 rst_l,
    input  logic                                 game_start,
    input  logic                                 fetch,
    input  logic                                 swap_in,
    input  tile_type_t                           swap_type,
    output tile_type_t                           falling_type,
    output logic                                 new_tetromino,
    output tile_type_t [PREVIEW_DEPTH-1:0]       preview,
    output logic [$clog2(PREVIEW_DEPTH+1)-1:0]   queue_count
);

    localparam int            CW   = $clog2(PREVIEW_DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(PREVIEW_DEPTH);

    npq_state_t                      r_state;
    npq_state_t                      w_state_nxt;
    tile_type_t [PREVIEW_DEPTH-1:0]  r_queue;
    tile_type_t [PREVIEW_DEPTH-1:0]  w_queue_nxt;
    logic [CW-1:0]                   r_count;
    logic [CW-1:0]                   w_count_nxt;
    logic [6:0]                      r_mask;
    logic [6:0]                      w_mask_nxt;
    logic                            r_pending;
    logic                            w_pending_nxt;
    tile_type_t                      r_falling;
    tile_type_t                      w_falling_nxt;
    logic                            r_new;
    logic                            w_new_nxt;

    logic [15:0]   w_lfsr;
    logic          w_unused;
    logic          w_active;
    logic          w_swap;
    logic          w_fetch;
    logic          w_pop;
    logic          w_gen;
    logic [2:0]    w_pick;
    logic [6:0]    w_mask_set;
    logic [CW-1:0] w_push_idx;

    lfsr16 #(
        .SEED   (LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst_l  (rst_l),
        .reload (game_start),
        .value  (w_lfsr)
    );

    assign w_unused = ^w_lfsr[15:3];

    // game_start preempts everything, so nothing else acts in its cycle.
    assign w_active   = (r_state != ST_IDLE) && !game_start;
    assign w_swap     = w_active && swap_in;
    assign w_fetch    = w_active && fetch && !swap_in;
    assign w_pop      = w_active && !swap_in
                        && (fetch || r_pending)
                        && (r_count != '0);
    assign w_gen      = w_active && (r_count < FULL);
    assign w_pick     = pick_piece(w_lfsr[2:0], r_mask);
    assign w_mask_set = r_mask | (7'd1 << w_pick);
    assign w_push_idx = r_count - CW'(w_pop);

    always_comb begin
        w_queue_nxt   = r_queue;
        w_count_nxt   = r_count;
        w_mask_nxt    = r_mask;
        w_pending_nxt = r_pending;
        w_falling_nxt = r_falling;
        w_new_nxt     = 1'b0;
        if (game_start) begin
            for (int i = 0; i < PREVIEW_DEPTH; i++) begin
                w_queue_nxt[i] = BLANK;
            end
            w_count_nxt   = '0;
            w_mask_nxt    = '0;
            w_pending_nxt = 1'b0;
            w_falling_nxt = BLANK;
        end else if (w_active) begin
            if (w_swap) begin
                w_falling_nxt = swap_type;
                w_new_nxt     = 1'b1;
            end else if (w_pop) begin
                w_falling_nxt = r_queue[0];
                w_new_nxt     = 1'b1;
                w_pending_nxt = 1'b0;
            end else if (w_fetch) begin
                w_pending_nxt = 1'b1;
            end
            if (w_pop) begin
                for (int i = 0; i < PREVIEW_DEPTH - 1; i++) begin
                    w_queue_nxt[i] = r_queue[i+1];
                end
                w_queue_nxt[PREVIEW_DEPTH-1] = BLANK;
            end
            if (w_gen) begin
                for (int i = 0; i < PREVIEW_DEPTH; i++) begin
                    if (w_push_idx == CW'(i)) begin
                        w_queue_nxt[i] = tile_type_t'(w_pick);
                    end
                end
                // A full bag restarts instead of latching all seven bits.
                w_mask_nxt = (w_mask_set == 7'h7F) ? 7'h00 : w_mask_set;
            end
            w_count_nxt = r_count - CW'(w_pop) + CW'(w_gen);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (game_start) begin
            w_state_nxt = ST_FILL;
        end else begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_IDLE;
                ST_FILL,
                ST_RUN:  w_state_nxt = (w_count_nxt == FULL) ? ST_RUN
                                                             : ST_FILL;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state   <= ST_IDLE;
            for (int i = 0; i < PREVIEW_DEPTH; i++) begin
                r_queue[i] <= BLANK;
            end
            r_count   <= '0;
            r_mask    <= '0;
            r_pending <= 1'b0;
            r_falling <= BLANK;
            r_new     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_queue   <= w_queue_nxt;
            r_count   <= w_count_nxt;
            r_mask    <= w_mask_nxt;
            r_pending <= w_pending_nxt;
            r_falling <= w_falling_nxt;
            r_new     <= w_new_nxt;
        end
    end

    assign falling_type  = r_falling;
    assign new_tetromino = r_new;
    assign preview       = r_queue;
    assign queue_count   = r_count;

endmodule

// File: tb/tb_next_piece_queue.sv
// Directed bench for next_piece_queue: vector table plus corner sequences,
// with a queue-based reference of the bag generator for piece types.
module tb_next_piece_queue;
    import DisplayPkg::*;

    localparam int          D    = 5;
    localparam logic [15:0] SEED = 16'hACE1;

    logic                 clk = 1'b0;
    logic                 rst_l;
    logic                 game_start;
    logic                 fetch;
    logic                 swap_in;
    tile_type_t           swap_type;
    tile_type_t           falling_type;
    logic                 new_tetromino;
    tile_type_t [D-1:0]   preview;
    logic [2:0]           queue_count;

    always #5 clk = ~clk;

    next_piece_queue #(
        .PREVIEW_DEPTH (D),
        .LFSR_SEED     (SEED)
    ) dut (
        .clk           (clk),
        .rst_l         (rst_l),
        .game_start    (game_start),
        .fetch         (fetch),
        .swap_in       (swap_in),
        .swap_type     (swap_type),
        .falling_type  (falling_type),
        .new_tetromino (new_tetromino),
        .preview       (preview),
        .queue_count   (queue_count)
    );

    int tests = 0;
    int fails = 0;

    logic [15:0] m_lfsr;
    bit          m_on;
    tile_type_t  mq[$];
    logic [6:0]  m_mask;
    bit          m_pend;
    tile_type_t  m_fall;
    bit          m_new;
    tile_type_t  issued[$];

    typedef struct {
        bit         gs;
        bit         f;
        bit         s;
        tile_type_t st;
        bit         exp_new;
        int         exp_cnt;
    } vec_t;

    vec_t vecs[21];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic tile_type_t m_pick(logic [15:0] l, logic [6:0] used);
        int j;
        j = (l[2:0] == 3'd7) ? 0 : int'(l[2:0]);
        for (int n = 0; n < 7 && used[j]; n++) j = (j + 1) % 7;
        return tile_type_t'(3'(j));
    endfunction

    task automatic model_reset();
        m_lfsr = SEED;
        m_on   = 0;
        mq.delete();
        m_mask = 0;
        m_pend = 0;
        m_fall = BLANK;
        m_new  = 0;
    endtask

    task automatic model_step(input bit gs, input bit f, input bit s,
                              input tile_type_t st);
        int         pre;
        tile_type_t p;
        m_new = 0;
        if (gs) begin
            m_on = 1;
            mq.delete();
            m_mask = 0;
            m_pend = 0;
            m_fall = BLANK;
            m_lfsr = SEED;
            return;
        end
        if (m_on) begin
            pre = mq.size();
            if (s) begin
                m_fall = st;
                m_new  = 1;
            end else if ((f || m_pend) && pre > 0) begin
                m_fall = mq.pop_front();
                m_new  = 1;
                m_pend = 0;
            end else if (f) begin
                m_pend = 1;
            end
            if (pre < D) begin
                p = m_pick(m_lfsr, m_mask);
                mq.push_back(p);
                m_mask = m_mask | 7'(1 << int'(p));
                if (m_mask == 7'h7F) m_mask = 0;
            end
        end
        m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
    endtask

    task automatic check_model();
        chk("falling_type", falling_type, m_fall);
        chk("new_tetromino", new_tetromino, m_new);
        chk("queue_count", queue_count, mq.size());
        for (int i = 0; i < D; i++) begin
            chk($sformatf("preview[%0d]", i), preview[i],
                (i < mq.size()) ? mq[i] : BLANK);
        end
    endtask

    task automatic step(input bit gs, input bit f, input bit s,
                        input tile_type_t st);
        @(negedge clk);
        game_start = gs;
        fetch      = f;
        swap_in    = s;
        swap_type  = st;
        @(posedge clk);
        model_step(gs, f, s, st);
        #1;
        check_model();
        if (new_tetromino) issued.push_back(falling_type);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, BLANK);
    endtask

    initial begin
        tile_type_t p0;
        logic [6:0] seen;

        vecs[0]  = '{0, 0, 0, BLANK,  0, 0};
        vecs[1]  = '{0, 1, 0, BLANK,  0, 0};
        vecs[2]  = '{0, 0, 1, TILE_T, 0, 0};
        vecs[3]  = '{1, 0, 0, BLANK,  0, 0};
        vecs[4]  = '{0, 1, 0, BLANK,  0, 1};
        vecs[5]  = '{0, 0, 0, BLANK,  1, 1};
        vecs[6]  = '{0, 0, 0, BLANK,  0, 2};
        vecs[7]  = '{0, 0, 0, BLANK,  0, 3};
        vecs[8]  = '{0, 0, 0, BLANK,  0, 4};
        vecs[9]  = '{0, 0, 0, BLANK,  0, 5};
        vecs[10] = '{0, 0, 0, BLANK,  0, 5};
        vecs[11] = '{0, 1, 0, BLANK,  1, 4};
        vecs[12] = '{0, 0, 0, BLANK,  0, 5};
        vecs[13] = '{0, 1, 1, TILE_T, 1, 5};
        vecs[14] = '{0, 0, 0, BLANK,  0, 5};
        vecs[15] = '{0, 1, 0, BLANK,  1, 4};
        vecs[16] = '{0, 1, 0, BLANK,  1, 4};
        vecs[17] = '{1, 0, 0, BLANK,  0, 0};
        vecs[18] = '{0, 0, 0, BLANK,  0, 1};
        vecs[19] = '{0, 0, 1, TILE_S, 1, 2};
        vecs[20] = '{0, 1, 0, BLANK,  1, 2};

        rst_l      = 1'b0;
        game_start = 1'b0;
        fetch      = 1'b0;
        swap_in    = 1'b0;
        swap_type  = BLANK;
        repeat (2) @(posedge clk);
        #1;
        chk("rst falling_type", falling_type, BLANK);
        chk("rst queue_count", queue_count, 0);
        chk("rst new_tetromino", new_tetromino, 0);
        for (int i = 0; i < D; i++)
            chk($sformatf("rst preview[%0d]", i), preview[i], BLANK);
        @(posedge clk);
        #1;
        rst_l = 1'b1;
        model_reset();

        for (int v = 0; v < 21; v++) begin
            step(vecs[v].gs, vecs[v].f, vecs[v].s, vecs[v].st);
            chk($sformatf("vec%0d new", v), new_tetromino, vecs[v].exp_new);
            chk($sformatf("vec%0d count", v), queue_count, vecs[v].exp_cnt);
            if (v == 13) chk("vec13 swap type", falling_type, TILE_T);
        end

        step(1, 0, 0, BLANK);
        idle(5);
        chk("fill count", queue_count, 5);
        for (int i = 0; i < D; i++) begin
            chk($sformatf("fill nonblank[%0d]", i), preview[i] != BLANK, 1);
            for (int j = i + 1; j < D; j++)
                chk($sformatf("fill distinct[%0d,%0d]", i, j),
                    preview[i] != preview[j], 1);
        end
        p0 = preview[0];
        step(0, 1, 0, BLANK);
        chk("fetch falling=prev0", falling_type, p0);
        chk("fetch pulse", new_tetromino, 1);
        idle(1);
        chk("pulse one cycle", new_tetromino, 0);

        chk("run count before restart", queue_count, 5);
        step(1, 0, 0, BLANK);
        chk("restart count", queue_count, 0);
        chk("restart falling", falling_type, BLANK);
        idle(5);
        chk("refill count", queue_count, 5);

        step(1, 0, 0, BLANK);
        issued.delete();
        for (int k = 0; k < 14; k++) begin
            step(0, 1, 0, BLANK);
            idle(2);
        end
        chk("issued count", issued.size(), 14);
        if (issued.size() == 14) begin
            seen = '0;
            for (int k = 0; k < 7; k++) seen = seen | 7'(1 << int'(issued[k]));
            chk("bag1 permutation", seen, 7'h7F);
            seen = '0;
            for (int k = 7; k < 14; k++) seen = seen | 7'(1 << int'(issued[k]));
            chk("bag2 permutation", seen, 7'h7F);
        end

        step(0, 1, 0, BLANK);
        #2;
        rst_l = 1'b0;
        #1;
        chk("async rst count", queue_count, 0);
        chk("async rst falling", falling_type, BLANK);
        chk("async rst new", new_tetromino, 0);
        chk("async rst preview0", preview[0], BLANK);
        @(posedge clk);
        #1;
        rst_l = 1'b1;
        model_reset();
        step(0, 1, 0, BLANK);
        chk("idle after rst count", queue_count, 0);
        step(1, 0, 0, BLANK);
        idle(3);
        chk("post rst fill", queue_count, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/next_piece_queue.md
NEXT_PIECE_QUEUE -- requirements
Module: next_piece_queue

Interface
REQ-001 Parameter PREVIEW_DEPTH, default 5, number of queued upcoming pieces (legal range 1..7).
REQ-002 Parameter LFSR_SEED, default 16'hACE1, nonzero LFSR reset and restart value.
REQ-003 Port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 Port rst_l  input  1  reset, asynchronous, active-low.
REQ-005 Port game_start  input  1  single-cycle pulse that clears and restarts the queue.
REQ-006 Port fetch  input  1  request to issue the next queued piece (lock event or hold-with-empty-slot).
REQ-007 Port swap_in  input  1  hold-swap request; the falling piece is replaced by swap_type.
REQ-008 Port swap_type  input  tile_type_t  current hold piece, valid when swap_in=1.
REQ-009 Port falling_type  output  tile_type_t  type of the active falling piece.
REQ-010 Port new_tetromino  output  1  single-cycle pulse on each falling_type update.
REQ-011 Port preview  output  tile_type_t[PREVIEW_DEPTH]  queued pieces; preview[0] issues next.
REQ-012 Port queue_count  output  $clog2(PREVIEW_DEPTH+1)  number of valid queue entries.

Function
REQ-013 States: IDLE (no game; no generation), FILL (queue_count < PREVIEW_DEPTH), RUN (queue full).
REQ-014 Transitions: IDLE->FILL on game_start; FILL->RUN when queue_count reaches PREVIEW_DEPTH; RUN->FILL after a pop; any state->FILL on game_start.
REQ-015 The 16-bit Fibonacci LFSR (taps 16,14,13,11) shall advance every cycle in all states.
REQ-016 Piece selection: idx = lfsr[2:0], with 7 mapped to 0; choose the first type not in the bag-used mask, searching from idx upward with wrap-around modulo 7.
REQ-017 The 7-bit bag-used mask shall set the chosen bit on each generation; it shall clear to 0 in the same cycle the 7th bit would be set.
REQ-018 In FILL or RUN, the block shall generate at most one piece per cycle, only when pre-pop queue_count < PREVIEW_DEPTH, appending it at index queue_count minus pops.
REQ-019 Fetch with queue_count>=1 at cycle t: falling_type=preview[0] at t+1, new_tetromino=1 during t+1 only, entries shift down one.
REQ-020 A fetch with queue_count=0 shall set a pending flag; the flag shall be served as REQ-019 in the cycle the first entry becomes valid.
REQ-021 Swap_in at cycle t: falling_type=swap_type at t+1, new_tetromino=1 during t+1 only; queue and mask unchanged.
REQ-022 Priority: game_start > swap_in > fetch; a lower-priority request in the same cycle shall be dropped, not pended.
REQ-023 A pop and a push in the same cycle shall both complete, leaving queue_count unchanged.
REQ-024 Invalid preview entries (index >= queue_count) shall read BLANK.
REQ-025 game_start shall, next cycle: set queue_count=0, all preview BLANK, falling_type=BLANK, mask=0, pending=0, new_tetromino=0, and reload LFSR with LFSR_SEED.
REQ-026 In IDLE, fetch and swap_in shall be ignored.

Reset
REQ-027 On rst_l low: state=IDLE, falling_type=BLANK, preview all BLANK, queue_count=0, new_tetromino=0, mask=0, pending=0, LFSR=LFSR_SEED.
REQ-028 Reset asserted mid-operation shall override all inputs immediately and asynchronously.

Structure
REQ-029 tile_type_t, NUM_TETROMINOS=7 and the default LFSR seed shall live in DisplayPkg; no new package shall be created.
REQ-030 The LFSR shall be a separate sub-module lfsr16 with ports clk, rst_l, reload, and 16-bit value.

Verification
REQ-031 Reset -> falling_type=BLANK, queue_count=0, all preview BLANK, new_tetromino=0.
REQ-032 game_start, idle 5 cycles -> queue_count=5, preview holds 5 distinct non-BLANK types; fetch -> next cycle falling_type equals prior preview[0], one-cycle new_tetromino pulse, preview shifted by one.
REQ-033 game_start, then 14 fetches spaced 3 cycles apart -> issued pieces 1-7 and 8-14 are each permutations of the 7 tetrominoes.
REQ-034 fetch in the cycle after game_start (count=0) -> no pulse that cycle; falling_type updates exactly one cycle after the first piece is enqueued.
REQ-035 swap_in=1 with swap_type=T and fetch=1 in the same cycle -> falling_type=T, queue_count and preview unchanged, single new_tetromino pulse.
REQ-036 game_start in RUN with count=5 and mask nonzero -> next cycle count=0, falling_type=BLANK; queue refills to 5 within 5 cycles.
